// File: rtl/sample_gen_pkg.sv
// rtl/sample_gen_pkg.sv - shared types for the sample generator stream block
package sample_gen_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    localparam int SAMPLE_DATA_W = 32;

    // Widest legal counter; narrower instances zero-extend into data.
    typedef struct packed {
        logic [SAMPLE_DATA_W-1:0] data;
        logic                     wrap;
    } sample_t;

endpackage

// File: rtl/sample_fifo2.sv
// rtl/sample_fifo2.sv - two-entry first-word-fall-through buffer
module sample_fifo2
    import sample_gen_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata
);

    occ_state_t        occ, occ_next;
    logic [DATA_W-1:0] slot0, slot1;
    logic              push, pop;

    assign s_tready = (occ != OCC_FULL);
    assign m_tvalid = (occ != OCC_EMPTY);
    assign m_tdata  = slot0;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (push) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_next = OCC_FULL;
                else if (pop && !push) occ_next = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    // slot0 is the head and only moves on a pop, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ   <= OCC_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            occ <= occ_next;
            case (occ)
                OCC_EMPTY: if (push) slot0 <= s_tdata;
                OCC_ONE: begin
                    if (push && pop) slot0 <= s_tdata;
                    else if (push)   slot1 <= s_tdata;
                end
                OCC_FULL:  if (pop) slot0 <= slot1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sample_gen_stream.sv
// rtl/sample_gen_stream.sv - command-driven up/down counter emitting buffered samples
module sample_gen_stream
    import sample_gen_pkg::*;
#(
    parameter int                WIDTH   = 8,
    parameter int unsigned       STEP    = 1,
    parameter longint unsigned   MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter int                SAT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enable,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap
);

    localparam longint unsigned MOD_L      = MAX_VAL + 64'd1;
    localparam longint unsigned STEP_MOD_L = STEP % MOD_L;
    localparam logic [WIDTH:0]  MAXV       = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]  MODV       = (WIDTH+1)'(MOD_L);
    localparam logic [WIDTH:0]  STEPV      = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]  STEP_MODV  = (WIDTH+1)'(STEP_MOD_L);
    localparam logic [WIDTH:0]  DN_ADDV    = (WIDTH+1)'(MOD_L - STEP_MOD_L);
    localparam int              PAYLOAD_W  = $bits(sample_t);

    logic [WIDTH-1:0]     cnt;
    logic [WIDTH:0]       cnt_w, up_raw, up_mod, dn_mod, load_w, next_cnt;
    logic                 next_wrap;
    logic                 accept, fifo_ready;
    sample_t              wr_s, rd_s;
    logic [PAYLOAD_W-1:0] fifo_rdata;
    logic                 unused_hi;

    assign in_ready = !reset && fifo_ready;
    assign accept   = in_valid && in_ready;

    assign cnt_w  = {1'b0, cnt};
    assign load_w = {1'b0, load_val};
    assign up_raw = cnt_w + STEPV;
    assign up_mod = cnt_w + STEP_MODV;
    assign dn_mod = cnt_w + DN_ADDV;

    // up_raw/STEPV decide whether a wrap happened; the *_MOD terms give the
    // residue so a STEP larger than the range still wraps correctly.
    always_comb begin
        next_cnt  = cnt_w;
        next_wrap = 1'b0;
        if (clr) begin
            next_cnt = '0;
        end else if (load) begin
            next_cnt = (load_w > MAXV) ? MAXV : load_w;
        end else if (enable) begin
            if (!dir) begin
                if (up_raw > MAXV) begin
                    next_wrap = 1'b1;
                    if (SAT != 0)          next_cnt = MAXV;
                    else if (up_mod > MAXV) next_cnt = up_mod - MODV;
                    else                    next_cnt = up_mod;
                end else begin
                    next_cnt = up_raw;
                end
            end else begin
                if (cnt_w < STEPV) begin
                    next_wrap = 1'b1;
                    if (SAT != 0)               next_cnt = '0;
                    else if (cnt_w >= STEP_MODV) next_cnt = cnt_w - STEP_MODV;
                    else                         next_cnt = dn_mod;
                end else begin
                    next_cnt = cnt_w - STEPV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       cnt <= '0;
        else if (accept) cnt <= next_cnt[WIDTH-1:0];
    end

    always_comb begin
        wr_s      = '0;
        wr_s.data = SAMPLE_DATA_W'(next_cnt);
        wr_s.wrap = next_wrap;
    end

    sample_fifo2 #(
        .DATA_W (PAYLOAD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (accept),
        .s_tready (fifo_ready),
        .s_tdata  (wr_s),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (fifo_rdata)
    );

    assign rd_s      = fifo_rdata;
    assign out_data  = rd_s.data[WIDTH-1:0];
    assign out_wrap  = rd_s.wrap;
    assign unused_hi = ^rd_s.data;

endmodule

// File: tb/tb_sample_gen_stream.sv
// tb/tb_sample_gen_stream.sv - self-checking bench for sample_gen_stream
module tb_sample_gen_stream;

    typedef struct {
        int data;
        bit wrap;
    } smp_t;

    localparam int NDUT = 3;
    localparam int MAXV [NDUT] = '{255, 100, 20};
    localparam int SATV [NDUT] = '{0, 1, 0};
    localparam int STPV [NDUT] = '{1, 1, 7};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       enable = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       out_ready = 1'b0;

    logic       ov [NDUT];
    logic       ordy [NDUT];
    logic       ow [NDUT];
    logic [7:0] od [NDUT];

    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   mcnt [NDUT];
    smp_t mq [NDUT][$];

    always #5 clk = ~clk;

    sample_gen_stream dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ordy[0]),
        .enable(enable), .clr(clr), .load(load), .load_val(load_val), .dir(dir),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_wrap(ow[0])
    );

    sample_gen_stream #(.WIDTH(8), .STEP(1), .MAX_VAL(100), .SAT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ordy[1]),
        .enable(enable), .clr(clr), .load(load), .load_val(load_val), .dir(dir),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_wrap(ow[1])
    );

    sample_gen_stream #(.WIDTH(8), .STEP(7), .MAX_VAL(20), .SAT(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ordy[2]),
        .enable(enable), .clr(clr), .load(load), .load_val(load_val), .dir(dir),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_wrap(ow[2])
    );

    function automatic smp_t model_cmd(int cnt, int i);
        smp_t r;
        int   m;
        m      = MAXV[i];
        r.data = cnt;
        r.wrap = 1'b0;
        if (clr) begin
            r.data = 0;
        end else if (load) begin
            r.data = (int'(load_val) > m) ? m : int'(load_val);
        end else if (enable && !dir) begin
            if (cnt + STPV[i] > m) begin
                r.wrap = 1'b1;
                r.data = SATV[i] != 0 ? m : (cnt + STPV[i]) % (m + 1);
            end else begin
                r.data = cnt + STPV[i];
            end
        end else if (enable) begin
            if (cnt < STPV[i]) begin
                r.wrap = 1'b1;
                r.data = SATV[i] != 0 ? 0 : (((cnt - STPV[i]) % (m + 1)) + (m + 1)) % (m + 1);
            end else begin
                r.data = cnt - STPV[i];
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mq[i].size() > 0));
            chk($sformatf("in_ready%0d", i), 32'(ordy[i]), 32'(!reset && mq[i].size() < 2));
            if (mq[i].size() > 0) begin
                chk($sformatf("data%0d", i), 32'(od[i]), 32'(mq[i][0].data));
                chk($sformatf("wrap%0d", i), 32'(ow[i]), 32'(mq[i][0].wrap));
            end
        end
    endtask

    // Inputs are set after a falling edge; the model follows the rising edge.
    task automatic tick();
        bit   acc;
        smp_t s;
        acc = in_valid && !reset && (mq[0].size() < 2);
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (reset) begin
                mq[i].delete();
                mcnt[i] = 0;
            end else begin
                if (mq[i].size() > 0 && out_ready) void'(mq[i].pop_front());
                if (acc) begin
                    s       = model_cmd(mcnt[i], i);
                    mcnt[i] = s.data;
                    mq[i].push_back(s);
                end
            end
        end
        if (acc) n_acc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic cmd(bit v, bit c, bit l, bit e, bit d, int lv);
        in_valid = v;
        clr      = c;
        load     = l;
        enable   = e;
        dir      = d;
        load_val = 8'(lv);
        tick();
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) mcnt[i] = 0;

        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(ov[0]), 0);
        chk("rst_data", 32'(od[0]), 0);
        chk("rst_wrap", 32'(ow[0]), 0);
        chk("rst_ready", 32'(ordy[0]), 0);
        reset = 1'b0;

        out_ready = 1'b1;
        cmd(1, 0, 0, 1, 0, 0);  chk("seq_d1", 32'(od[0]), 1);
        cmd(1, 0, 0, 1, 0, 0);  chk("seq_d2", 32'(od[0]), 2);
        cmd(1, 0, 0, 1, 0, 0);  chk("seq_d3", 32'(od[0]), 3);
        chk("seq_w3", 32'(ow[0]), 0);
        cmd(0, 0, 0, 0, 0, 0);

        cmd(1, 0, 1, 0, 0, 254); chk("wrap_ld", 32'(od[0]), 254);
        cmd(1, 0, 0, 1, 0, 0);   chk("wrap_255", 32'(od[0]), 255);
        chk("wrap_255w", 32'(ow[0]), 0);
        cmd(1, 0, 0, 1, 0, 0);   chk("wrap_0", 32'(od[0]), 0);
        chk("wrap_0w", 32'(ow[0]), 1);
        cmd(1, 0, 0, 1, 1, 0);   chk("wrap_dn", 32'(od[0]), 255);
        chk("wrap_dnw", 32'(ow[0]), 1);
        cmd(0, 0, 0, 0, 0, 0);

        cmd(1, 0, 1, 0, 0, 99);  chk("sat_99", 32'(od[1]), 99);
        cmd(1, 0, 0, 1, 0, 0);   chk("sat_100", 32'(od[1]), 100);
        chk("sat_100w", 32'(ow[1]), 0);
        cmd(1, 0, 0, 1, 0, 0);   chk("sat_clamp", 32'(od[1]), 100);
        chk("sat_clampw", 32'(ow[1]), 1);
        cmd(1, 0, 1, 0, 0, 0);   chk("sat_ld0", 32'(od[1]), 0);
        cmd(1, 0, 0, 1, 1, 0);   chk("sat_dn0", 32'(od[1]), 0);
        chk("sat_dn0w", 32'(ow[1]), 1);
        cmd(0, 0, 0, 0, 0, 0);

        out_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 4; k++) cmd(1, 0, 0, 1, 0, 0);
        chk("bp_accepted", 32'(n_acc), 2);
        chk("bp_ready", 32'(ordy[0]), 0);
        chk("bp_hold", 32'(od[0]), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && n_acc < 4; k++) cmd(1, 0, 0, 1, 0, 0);
        chk("bp_release", 32'(n_acc), 4);
        cmd(0, 0, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 0);

        cmd(1, 0, 1, 0, 0, 50);  chk("pri_ld50", 32'(od[0]), 50);
        cmd(1, 1, 1, 1, 0, 77);  chk("pri_clr", 32'(od[0]), 0);
        cmd(0, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        cmd(1, 0, 0, 1, 0, 0);
        cmd(1, 0, 0, 1, 0, 0);
        chk("full_ready", 32'(ordy[0]), 0);
        reset = 1'b1;
        cmd(1, 0, 0, 1, 0, 0);
        chk("mid_rst_valid", 32'(ov[0]), 0);
        chk("mid_rst_data", 32'(od[0]), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        cmd(1, 0, 0, 1, 0, 0);   chk("post_rst", 32'(od[0]), 1);

        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cmd($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_gen_stream.md
SAMPLE_GEN_STREAM -- requirements
Module: sample_gen_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and sample width in bits, legal range 2..32.
REQ-002 SHALL have parameter STEP, default 1: increment/decrement magnitude, 1..2**WIDTH-1.
REQ-003 SHALL have parameter MAX_VAL, default 2**WIDTH-1: upper count bound.
REQ-004 SHALL have parameter SAT, default 0: 0 = wrap modulo MAX_VAL+1; 1 = saturate at 0/MAX_VAL.
REQ-005 SHALL have port clk  in  1: single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1: command present.
REQ-008 SHALL have port in_ready  out  1: command accepted when in_valid&in_ready at an edge.
REQ-009 SHALL have port enable  in  1: command field, step counter.
REQ-010 SHALL have port clr  in  1: command field, clear counter.
REQ-011 SHALL have port load  in  1: command field, load counter from load_val.
REQ-012 SHALL have port load_val  in  WIDTH: load value.
REQ-013 SHALL have port dir  in  1: 0 = up, 1 = down.
REQ-014 SHALL have port out_valid  out  1: sample present.
REQ-015 SHALL have port out_ready  in  1: sample consumed when out_valid&out_ready at an edge.
REQ-016 SHALL have port out_data  out  WIDTH: sample value.
REQ-017 SHALL have port out_wrap  out  1: sample produced by a wrap or saturation event.

Function
REQ-018 Each accepted command SHALL update the counter at that edge and push exactly one sample (post-update value, wrap flag) into a 2-entry output buffer.
REQ-019 Command priority SHALL be clr > load > enable; no field set SHALL leave counter unchanged and still emit a sample.
REQ-020 load_val > MAX_VAL SHALL be clamped to MAX_VAL.
REQ-021 Up step with SAT=0 SHALL compute (cnt+STEP) mod (MAX_VAL+1), with out_wrap=1 when cnt+STEP > MAX_VAL.
REQ-022 Down step with SAT=0 SHALL compute (cnt-STEP) mod (MAX_VAL+1), with out_wrap=1 when cnt < STEP.
REQ-023 With SAT=1, up SHALL clamp at MAX_VAL and down SHALL clamp at 0; out_wrap=1 when clamping occurred.
REQ-024 Intermediate arithmetic SHALL be WIDTH+1 bits; no truncation before the bound compare.
REQ-025 in_ready SHALL be 1 iff buffer occupancy < 2 and reset is low; it SHALL NOT depend combinationally on out_ready.
REQ-026 Latency SHALL be 1: a command accepted at edge k gives out_valid=1 in cycle k+1 when the buffer was empty.
REQ-027 Buffer order SHALL be FIFO, occupancy states EMPTY, ONE, FULL; push-only increments, pop-only decrements, push+pop in ONE stays ONE.
REQ-028 out_data/out_wrap SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Sustained in_valid=out_ready=1 SHALL sustain one sample per cycle.

Reset
REQ-030 reset high at an edge SHALL set counter=0, buffer EMPTY, out_valid=0, out_data=0, out_wrap=0; in_ready=0 while reset is high.
REQ-031 reset mid-operation SHALL discard buffered samples, with no sample from that cycle's command.

Structure
REQ-032 Package sample_gen_pkg SHALL hold the occupancy-state enum and the sample struct {data, wrap}.
REQ-033 The 2-entry buffer SHALL be a sub-module sample_fifo2 parametrised on payload width.

Verification
REQ-034 WIDTH=8, SAT=0: reset, then 3 enable commands with out_ready=1 -> samples 1,2,3, out_wrap=0, each 1 cycle after its accept.
REQ-035 WIDTH=8, SAT=0: load 254, then 2 enable up -> samples 254, 255, 0; out_wrap=1 only on 0; then dir=1 enable -> 255 wrap=1.
REQ-036 SAT=1, MAX_VAL=100: load 99, then 2 enable up -> 99, 100, 100 (wrap=1); then load 0, down -> 0, 0 (wrap=1).
REQ-037 out_ready=0 with 4 commands offered -> 2 accepted, in_ready=0, out_data held; then release -> samples in order, then the remaining commands accepted.
REQ-038 clr+load+enable together with cnt=50 -> sample 0; reset asserted with buffer FULL -> next cycle out_valid=0, counter 0.
